// File: rtl/fir_coeff_seq_ctrl_if.sv
// Host write port and datapath-facing enables/coefficient bus for fir_coeff_seq_ctrl.
interface fir_coeff_seq_ctrl_if #(
    parameter int unsigned NUM_TAPS = 10,
    parameter int unsigned COEFF_W  = 16
);
    logic                          coeff_wr_en;
    logic [3:0]                    coeff_addr;
    logic signed [COEFF_W-1:0]     coeff_data;
    logic                          coeff_commit;
    logic                          coeff_busy;
    logic                          wr_err;
    logic                          coeff_valid;
    logic                          en_sample_300k;
    logic [3:0]                    en_mul;
    logic                          en_add;
    logic                          en_acc;
    logic [NUM_TAPS*COEFF_W-1:0]   coeff_bus;

    modport master (
        output coeff_wr_en, coeff_addr, coeff_data, coeff_commit,
        input  coeff_busy, wr_err, coeff_valid, en_sample_300k,
               en_mul, en_add, en_acc, coeff_bus
    );

    modport slave (
        input  coeff_wr_en, coeff_addr, coeff_data, coeff_commit,
        output coeff_busy, wr_err, coeff_valid, en_sample_300k,
               en_mul, en_add, en_acc, coeff_bus
    );
endinterface

// File: rtl/fir_coeff_seq_ctrl.sv
// Sample divider, phase enables and double-buffered FIR coefficient bank.
// Define FIR_COEFF_SYM_EN for symmetric (mirrored-tap) coefficient writes.
module fir_coeff_seq_ctrl #(
    parameter int unsigned DIV_RATIO = 40,
    parameter int unsigned NUM_TAPS  = 10,
    parameter int unsigned COEFF_W   = 16
) (
    input logic                  iClk_12M,
    input logic                  iRst,
    fir_coeff_seq_ctrl_if.slave  bus
);
    localparam logic [7:0] LAST = 8'(DIV_RATIO - 1);

    typedef enum logic {IDLE, PENDING} state_t;

    state_t                    state;
    logic [7:0]                cnt;
    logic                      en_sample;
    logic [3:0]                en_mul;
    logic                      en_add;
    logic                      en_acc;
    logic                      busy;
    logic                      wr_err;
    logic                      valid;
    logic [COEFF_W-1:0]        shadow [NUM_TAPS];
    logic [COEFF_W-1:0]        active [NUM_TAPS];
    logic                      addr_ok;
    logic [NUM_TAPS*COEFF_W-1:0] coeff_bus;

`ifdef FIR_COEFF_SYM_EN
    logic [3:0] mirror;
    assign mirror  = 4'(NUM_TAPS - 1) - bus.coeff_addr;
    assign addr_ok = 32'(bus.coeff_addr) < (NUM_TAPS / 2);
`else
    assign addr_ok = 32'(bus.coeff_addr) < NUM_TAPS;
`endif

    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            state     <= IDLE;
            cnt       <= '0;
            en_sample <= 1'b0;
            en_mul    <= '0;
            en_add    <= 1'b0;
            en_acc    <= 1'b0;
            busy      <= 1'b0;
            wr_err    <= 1'b0;
            valid     <= 1'b0;
            for (int unsigned k = 0; k < NUM_TAPS; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            cnt       <= (cnt == LAST) ? '0 : cnt + 8'd1;
            en_sample <= (cnt == LAST);
            en_mul    <= {cnt == 8'd4, cnt == 8'd3, cnt == 8'd2, cnt == 8'd1};
            en_add    <= (cnt == 8'd5);
            en_acc    <= (cnt == 8'd6);
            wr_err    <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.coeff_wr_en) begin
                        if (addr_ok) begin
                            shadow[bus.coeff_addr] <= bus.coeff_data;
`ifdef FIR_COEFF_SYM_EN
                            shadow[mirror] <= bus.coeff_data;
`endif
                        end else begin
                            wr_err <= 1'b1;
                        end
                    end
                    // The write above lands on this edge, so a same-cycle commit includes it.
                    if (bus.coeff_commit) begin
                        state <= PENDING;
                        busy  <= 1'b1;
                    end
                end
                PENDING: begin
                    if (bus.coeff_wr_en || bus.coeff_commit) begin
                        wr_err <= 1'b1;
                    end
                    // Downstream latches the old bank on this same strobe edge.
                    if (en_sample) begin
                        for (int unsigned k = 0; k < NUM_TAPS; k++) begin
                            active[k] <= shadow[k];
                        end
                        valid <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        coeff_bus = '0;
        for (int unsigned k = 0; k < NUM_TAPS; k++) begin
            coeff_bus[k*COEFF_W +: COEFF_W] = active[k];
        end
    end

    assign bus.coeff_busy     = busy;
    assign bus.wr_err         = wr_err;
    assign bus.coeff_valid    = valid;
    assign bus.en_sample_300k = en_sample;
    assign bus.en_mul         = en_mul;
    assign bus.en_add         = en_add;
    assign bus.en_acc         = en_acc;
    assign bus.coeff_bus      = coeff_bus;
endmodule
